// File: rtl/snescmd_cmd_reader.sv
// snescmd_cmd_reader: captures 0x8X command bytes written to snescmd address 0x000
// by the writer or by SNES code, queues {src, data}, serves them to the MCU over an
// IRQ/ack handshake and writes 0x00 back to 0x000 to rearm the mailbox.
// Latency: push at N -> head visible at N+1; ack at N -> next head at N+1; clear >= N+1.
// Backpressure: snescmd_rdy drops below two free slots or while a clear is pending;
// candidates that find no slot are dropped and counted.
// Optional macro SNESCMD_RD_TIMEOUT_EN: drops a head left unacked for TIMEOUT cycles.
module snescmd_cmd_reader #(
  parameter int          DEPTH   = 4,
  parameter logic [23:0] TIMEOUT = 24'd8400000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cheat_we,
  input  logic [8:0] cheat_addr,
  input  logic [7:0] cheat_data,
  input  logic       snes_we,
  input  logic [8:0] snes_addr,
  input  logic [7:0] snes_data,
  input  logic       bus_busy,
  output logic       snescmd_rdy,
  output logic       clr_we,
  output logic [8:0] clr_addr,
  output logic [7:0] clr_data,
  output logic       mcu_cmd_valid,
  output logic [7:0] mcu_cmd_data,
  output logic       mcu_cmd_src,
  input  logic       mcu_cmd_ack,
  output logic       mcu_irq,
  output logic [7:0] drop_count,
  output logic       timeout_flag
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Parameter sanity: DEPTH must be a power of two in 2..16, TIMEOUT non-zero.
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT == 24'd0) begin : g_param_check
    $error("snescmd_cmd_reader: illegal DEPTH or TIMEOUT");
  end

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  logic [8:0]    fifo_mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, wptr_nxt;
  logic [CW-1:0] count_q, count_d, free_slots;
  logic [7:0]    drop_q, drop_d;
  logic [8:0]    drop_sum;
  logic [1:0]    push_n, drop_n;
  state_t        state_q, state_d;
  logic          clr_we_q, clr_we_d;
  logic          rdy_q, rdy_d;
  logic          snes_cand, cheat_cand, snes_acc, cheat_acc;
  logic          wr_en0, wr_en1, pop, head_vld, timeout_hit;
  logic [8:0]    wr_ent0, wr_ent1;

  assign snes_cand  = snes_we  && (snes_addr  == 9'h000) && (snes_data[7:4]  == 4'h8);
  assign cheat_cand = cheat_we && (cheat_addr == 9'h000) && (cheat_data[7:4] == 4'h8);
  assign head_vld   = (count_q != '0);
  assign free_slots = CW'(DEPTH) - count_q;

`ifdef SNESCMD_RD_TIMEOUT_EN
  logic [23:0] age_q, age_d;
  logic        tflag_q, tflag_d;

  // Head age: restarts whenever the head changes or the FIFO is empty.
  always_comb begin
    timeout_hit = head_vld && (age_q == TIMEOUT - 24'd1);
    age_d       = age_q + 24'd1;
    if (!head_vld || pop) age_d = '0;
    tflag_d     = tflag_q | timeout_hit;
  end

  // Age counter and sticky timeout flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_q   <= '0;
      tflag_q <= 1'b0;
    end else begin
      age_q   <= age_d;
      tflag_q <= tflag_d;
    end
  end

  assign timeout_flag = tflag_q;
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // Push arbitration (SNES first), pop, pointer/occupancy and drop-count updates.
  always_comb begin
    snes_acc  = snes_cand && (free_slots != '0);
    cheat_acc = cheat_cand && (snes_acc ? (free_slots >= CW'(2)) : (free_slots != '0));
    wr_en0    = snes_acc | cheat_acc;
    wr_en1    = snes_acc & cheat_acc;
    wr_ent0   = snes_acc ? {1'b0, snes_data} : {1'b1, cheat_data};
    wr_ent1   = {1'b1, cheat_data};
    wptr_nxt  = wptr_q + AW'(1);
    push_n    = 2'(wr_en0) + 2'(wr_en1);
    pop       = head_vld && (mcu_cmd_ack || timeout_hit);
    count_d   = count_q + CW'(push_n) - CW'(pop);
    wptr_d    = wptr_q + AW'(push_n);
    rptr_d    = rptr_q + AW'(pop);
    drop_n    = 2'(snes_cand & ~snes_acc) + 2'(cheat_cand & ~cheat_acc) + 2'(timeout_hit);
    drop_sum  = {1'b0, drop_q} + 9'(drop_n);
    drop_d    = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // FIFO storage, pointers, occupancy and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) fifo_mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      if (wr_en0) fifo_mem_q[wptr_q]   <= wr_ent0;
      if (wr_en1) fifo_mem_q[wptr_nxt] <= wr_ent1;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  // Clear FSM next state: the rearm write waits for a free bus cycle with no
  // competing command write to address 0, so it can never overwrite a new command.
  always_comb begin
    state_d  = state_q;
    clr_we_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_en0) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (!bus_busy && !snes_cand && !cheat_cand) begin
          clr_we_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rdy_d = ((CW'(DEPTH) - count_d) >= CW'(2)) && (state_d != ST_CLEAR);
  end

  // Clear FSM state with registered clear strobe and writer ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      clr_we_q <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      clr_we_q <= clr_we_d;
      rdy_q    <= rdy_d;
    end
  end

  assign snescmd_rdy   = rdy_q;
  assign clr_we        = clr_we_q;
  assign clr_addr      = 9'h000;
  assign clr_data      = 8'h00;
  assign mcu_cmd_valid = head_vld;
  assign mcu_irq       = head_vld;
  assign mcu_cmd_data  = fifo_mem_q[rptr_q][7:0];
  assign mcu_cmd_src   = fifo_mem_q[rptr_q][8];
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_snescmd_cmd_reader.sv
// Bench for snescmd_cmd_reader: vector table for the single-cycle behaviour plus
// hand sequences (bus_busy stall, streaming push/ack, mid-run reset, timeout)
// with a queue of expected {src, data} entries compared on every ack.
module tb_snescmd_cmd_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cheat_we, snes_we, bus_busy, mcu_cmd_ack;
  logic [8:0] cheat_addr, snes_addr;
  logic [7:0] cheat_data, snes_data;
  logic       snescmd_rdy, clr_we, mcu_cmd_valid, mcu_cmd_src, mcu_irq, timeout_flag;
  logic [8:0] clr_addr;
  logic [7:0] clr_data, mcu_cmd_data, drop_count;

  int checks   = 0;
  int failures = 0;

  logic [8:0] sb_q [$];

  snescmd_cmd_reader #(.DEPTH(4), .TIMEOUT(24'd16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cheat_we(cheat_we), .cheat_addr(cheat_addr), .cheat_data(cheat_data),
    .snes_we(snes_we), .snes_addr(snes_addr), .snes_data(snes_data),
    .bus_busy(bus_busy), .snescmd_rdy(snescmd_rdy),
    .clr_we(clr_we), .clr_addr(clr_addr), .clr_data(clr_data),
    .mcu_cmd_valid(mcu_cmd_valid), .mcu_cmd_data(mcu_cmd_data), .mcu_cmd_src(mcu_cmd_src),
    .mcu_cmd_ack(mcu_cmd_ack), .mcu_irq(mcu_irq),
    .drop_count(drop_count), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s_we;
    logic [8:0] s_addr;
    logic [7:0] s_dat;
    logic       c_we;
    logic [8:0] c_addr;
    logic [7:0] c_dat;
    logic       ack;
    logic       e_vld;
    logic [7:0] e_dat;
    logic       e_src;
    logic       e_rdy;
    logic       e_clr;
    logic [7:0] e_drop;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(input logic sw, input logic [7:0] sd, input logic cw,
                              input logic [7:0] cd, input logic ak, input logic ev,
                              input logic [7:0] ed, input logic es, input logic er,
                              input logic ec, input logic [7:0] edr);
    vec_t v;
    v.s_we = sw; v.s_addr = 9'h000; v.s_dat = sd;
    v.c_we = cw; v.c_addr = 9'h000; v.c_dat = cd;
    v.ack = ak; v.e_vld = ev; v.e_dat = ed; v.e_src = es;
    v.e_rdy = er; v.e_clr = ec; v.e_drop = edr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cheat_we = 1'b0; cheat_addr = 9'h000; cheat_data = 8'h00;
    snes_we  = 1'b0; snes_addr  = 9'h000; snes_data  = 8'h00;
    mcu_cmd_ack = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vld"},   {31'd0, mcu_cmd_valid}, 32'd0);
    check({tag, "_irq"},   {31'd0, mcu_irq},       32'd0);
    check({tag, "_dat"},   {24'd0, mcu_cmd_data},  32'd0);
    check({tag, "_src"},   {31'd0, mcu_cmd_src},   32'd0);
    check({tag, "_rdy"},   {31'd0, snescmd_rdy},   32'd1);
    check({tag, "_clr"},   {31'd0, clr_we},        32'd0);
    check({tag, "_drop"},  {24'd0, drop_count},    32'd0);
    check({tag, "_tflag"}, {31'd0, timeout_flag},  32'd0);
  endtask

  // Acks every valid head, comparing it with the oldest expected entry.
  task automatic drain(input string tag);
    logic [8:0] exp_ent;
    for (int n = 0; n < 20; n++) begin
      if (!mcu_cmd_valid) break;
      if (sb_q.size() == 0) begin
        check({tag, "_unexpected_head"}, {23'd0, mcu_cmd_src, mcu_cmd_data}, 32'h1ff);
        exp_ent = 9'h000;
      end else begin
        exp_ent = sb_q.pop_front();
        check({tag, "_head"}, {23'd0, mcu_cmd_src, mcu_cmd_data}, {23'd0, exp_ent});
      end
      mcu_cmd_ack = 1'b1;
      tick();
      mcu_cmd_ack = 1'b0;
    end
    check({tag, "_drained_vld"}, {31'd0, mcu_cmd_valid}, 32'd0);
    check({tag, "_sb_left"}, sb_q.size(), 32'd0);
  endtask

  initial begin
    logic       src;
    logic [7:0] dat;
    int         cnt;

    vecs[0]  = mk(0, 8'h00, 1, 8'h81, 0,  1, 8'h81, 1,  0, 0, 8'd0);
    vecs[1]  = mk(0, 8'h00, 0, 8'h00, 0,  1, 8'h81, 1,  1, 1, 8'd0);
    vecs[2]  = mk(0, 8'h00, 0, 8'h00, 1,  0, 8'h00, 0,  1, 0, 8'd0);
    vecs[3]  = mk(1, 8'h80, 1, 8'h85, 0,  1, 8'h80, 0,  0, 0, 8'd0);
    vecs[4]  = mk(0, 8'h00, 0, 8'h00, 0,  1, 8'h80, 0,  1, 1, 8'd0);
    vecs[5]  = mk(0, 8'h00, 0, 8'h00, 1,  1, 8'h85, 1,  1, 0, 8'd0);
    vecs[6]  = mk(0, 8'h00, 0, 8'h00, 1,  0, 8'h00, 0,  1, 0, 8'd0);
    vecs[7]  = mk(1, 8'h22, 1, 8'h83, 0,  0, 8'h00, 0,  1, 0, 8'd0);
    vecs[7].c_addr = 9'h001;
    vecs[8]  = mk(1, 8'h82, 1, 8'h83, 0,  1, 8'h82, 0,  0, 0, 8'd0);
    vecs[9]  = mk(1, 8'h84, 0, 8'h00, 0,  1, 8'h82, 0,  0, 0, 8'd0);
    vecs[10] = mk(0, 8'h00, 1, 8'h86, 0,  1, 8'h82, 0,  0, 0, 8'd0);
    vecs[11] = mk(1, 8'h87, 0, 8'h00, 0,  1, 8'h82, 0,  0, 0, 8'd1);
    vecs[12] = mk(1, 8'h88, 1, 8'h89, 0,  1, 8'h82, 0,  0, 0, 8'd3);
    vecs[13] = mk(0, 8'h00, 0, 8'h00, 0,  1, 8'h82, 0,  0, 1, 8'd3);
    vecs[14] = mk(0, 8'h00, 0, 8'h00, 1,  1, 8'h83, 1,  0, 0, 8'd3);
    vecs[15] = mk(0, 8'h00, 0, 8'h00, 1,  1, 8'h84, 0,  1, 0, 8'd3);
    vecs[16] = mk(1, 8'h8A, 0, 8'h00, 1,  1, 8'h86, 1,  0, 0, 8'd3);
    vecs[17] = mk(0, 8'h00, 0, 8'h00, 1,  1, 8'h8A, 0,  1, 1, 8'd3);
    vecs[18] = mk(0, 8'h00, 0, 8'h00, 1,  0, 8'h00, 0,  1, 0, 8'd3);
    vecs[19] = mk(0, 8'h00, 0, 8'h00, 1,  0, 8'h00, 0,  1, 0, 8'd3);

    rst_n = 1'b0;
    bus_busy = 1'b0;
    idle_inputs();
    tick();
    tick();
    check_reset_outputs("reset");
    check("reset_clr_addr", {23'd0, clr_addr}, 32'd0);
    check("reset_clr_data", {24'd0, clr_data}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Vector table: one clock per record, outputs checked after the edge.
    for (int i = 0; i < 20; i++) begin
      snes_we = vecs[i].s_we; snes_addr = vecs[i].s_addr; snes_data = vecs[i].s_dat;
      cheat_we = vecs[i].c_we; cheat_addr = vecs[i].c_addr; cheat_data = vecs[i].c_dat;
      mcu_cmd_ack = vecs[i].ack;
      tick();
      check($sformatf("v%0d_vld", i),  {31'd0, mcu_cmd_valid}, {31'd0, vecs[i].e_vld});
      check($sformatf("v%0d_irq", i),  {31'd0, mcu_irq},       {31'd0, vecs[i].e_vld});
      check($sformatf("v%0d_rdy", i),  {31'd0, snescmd_rdy},   {31'd0, vecs[i].e_rdy});
      check($sformatf("v%0d_clr", i),  {31'd0, clr_we},        {31'd0, vecs[i].e_clr});
      check($sformatf("v%0d_drop", i), {24'd0, drop_count},    {24'd0, vecs[i].e_drop});
      if (vecs[i].e_vld) begin
        check($sformatf("v%0d_dat", i), {24'd0, mcu_cmd_data}, {24'd0, vecs[i].e_dat});
        check($sformatf("v%0d_src", i), {31'd0, mcu_cmd_src},  {31'd0, vecs[i].e_src});
      end
    end
    idle_inputs();

    // bus_busy stalls the rearm write; a non-command write to 0 is ignored.
    bus_busy = 1'b1;
    cheat_we = 1'b1; cheat_data = 8'h8B;
    sb_q.push_back({1'b1, 8'h8B});
    tick();
    idle_inputs();
    check("busy_clr_first", {31'd0, clr_we}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin
        snes_we = 1'b1; snes_data = 8'h22;
      end
      tick();
      idle_inputs();
      check($sformatf("busy_clr_%0d", k), {31'd0, clr_we}, 32'd0);
      if (k == 4) begin
        check("busy_ignored_drop", {24'd0, drop_count}, 32'd3);
        check("busy_rdy_pending", {31'd0, snescmd_rdy}, 32'd0);
      end
    end
    bus_busy = 1'b0;
    tick();
    check("busy_clr_pulse", {31'd0, clr_we}, 32'd1);
    check("busy_clr_addr", {23'd0, clr_addr}, 32'd0);
    check("busy_clr_data", {24'd0, clr_data}, 32'd0);
    tick();
    check("busy_clr_once", {31'd0, clr_we}, 32'd0);
    drain("busy");

    // Streaming: one push per cycle with the previous head acked in the same cycle.
    for (int i = 0; i < 8; i++) begin
      src = 1'($urandom_range(0, 1));
      dat = {4'h8, 4'($urandom_range(0, 15))};
      if (mcu_cmd_valid) begin
        if (sb_q.size() != 0)
          check($sformatf("stream_head_%0d", i), {23'd0, mcu_cmd_src, mcu_cmd_data},
                {23'd0, sb_q.pop_front()});
        mcu_cmd_ack = 1'b1;
      end
      if (src) begin cheat_we = 1'b1; cheat_data = dat; end
      else     begin snes_we  = 1'b1; snes_data  = dat; end
      sb_q.push_back({src, dat});
      tick();
      idle_inputs();
    end
    drain("stream");
    check("stream_drop", {24'd0, drop_count}, 32'd3);

    // Reset mid-operation with three entries queued and a clear pending.
    snes_we = 1'b1; snes_data = 8'h81; cheat_we = 1'b1; cheat_data = 8'h82;
    tick();
    idle_inputs();
    snes_we = 1'b1; snes_data = 8'h83;
    tick();
    idle_inputs();
    check("prerst_vld", {31'd0, mcu_cmd_valid}, 32'd1);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("rst_async");
    tick();
    tick();
    check_reset_outputs("rst_held");
    rst_n = 1'b1;
    sb_q.delete();
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("postrst_clr_%0d", k), {31'd0, clr_we}, 32'd0);
      check($sformatf("postrst_vld_%0d", k), {31'd0, mcu_cmd_valid}, 32'd0);
      check($sformatf("postrst_rdy_%0d", k), {31'd0, snescmd_rdy}, 32'd1);
    end

`ifdef SNESCMD_RD_TIMEOUT_EN
    // Unacked head is dropped after 16 valid cycles.
    cheat_we = 1'b1; cheat_data = 8'h8C;
    tick();
    idle_inputs();
    cnt = 0;
    while (mcu_cmd_valid && cnt < 40) begin
      cnt++;
      tick();
    end
    check("timeout_cycles", cnt, 32'd16);
    check("timeout_drop", {24'd0, drop_count}, 32'd1);
    check("timeout_flag", {31'd0, timeout_flag}, 32'd1);
`else
    // Without the timeout feature a head waits indefinitely.
    cheat_we = 1'b1; cheat_data = 8'h8C;
    tick();
    idle_inputs();
    cnt = 0;
    while (mcu_cmd_valid && cnt < 40) begin
      cnt++;
      tick();
    end
    check("no_timeout_cycles", cnt, 32'd40);
    check("no_timeout_drop", {24'd0, drop_count}, 32'd0);
    check("no_timeout_flag", {31'd0, timeout_flag}, 32'd0);
    sb_q.push_back({1'b1, 8'h8C});
    drain("no_timeout");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
